// File: rtl/descriptor_input_receiver.sv
`default_nettype none
// ============================================================================
// Module   : descriptor_input_receiver
// Brief    : Descriptor receive FIFO with registered ack, show-ahead output
//            and a saturating overflow drop counter.
// Revision : 1.0
// ============================================================================
module descriptor_input_receiver #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [39:0]   iv_descriptor,
    input  logic          i_descriptor_wr,
    output logic          o_descriptor_ack,
    output logic [39:0]   ov_descriptor,
    output logic          o_descriptor_valid,
    input  logic          i_descriptor_rd,
    output logic [AW:0]   ov_fifo_usedw,
    output logic          o_fifo_full,
    output logic          o_descriptor_drop,
    output logic [15:0]   ov_drop_cnt
);

    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [39:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_ack;
    logic          r_drop;
    logic [15:0]   r_drop_cnt;

    logic          w_pop;
    logic          w_push_ok;
    logic          w_drop;

    // A write while full is still accepted when the head leaves in the same cycle.
    assign w_pop     = i_descriptor_rd & (r_count != '0);
    assign w_push_ok = i_descriptor_wr & ((r_count < c_DEPTH) | w_pop);
    assign w_drop    = i_descriptor_wr & ~w_push_ok;

    always_ff @(posedge i_clk) begin
        if (w_push_ok && !i_rst) begin
            r_mem[r_wr_ptr] <= iv_descriptor;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ack      <= 1'b0;
            r_drop     <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_ack  <= w_push_ok;
            r_drop <= w_drop;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push_ok) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop && (r_drop_cnt != c_CNT_MAX)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign o_descriptor_ack   = r_ack;
    assign o_descriptor_drop  = r_drop;
    assign ov_drop_cnt        = r_drop_cnt;
    assign ov_descriptor      = r_mem[r_rd_ptr];
    assign o_descriptor_valid = (r_count != '0);
    assign o_fifo_full        = (r_count == c_DEPTH);
    assign ov_fifo_usedw      = r_count;

endmodule
`default_nettype wire

// File: doc/descriptor_input_receiver.md
Name: descriptor_input_receiver

Overview:
- Receiving end of the descriptor interface driven by the descriptor merge stage (40-bit descriptor plus one-cycle write strobe, acknowledge returned).
- Accepts each descriptor, returns an ack pulse, and buffers descriptors in a small FIFO.
- Presents them in order to the input-queue manager over a valid/read handshake.
- Counts descriptors dropped on overflow.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- AW, 3, pointer width; log2(DEPTH).

Ports:
- i_clk  input  1  single clock for all logic.
- i_rst  input  1  synchronous reset, active-high.
- iv_descriptor  input  40  incoming descriptor, valid only while i_descriptor_wr=1.
- i_descriptor_wr  input  1  write strobe; each cycle high carries one descriptor.
- o_descriptor_ack  output  1  one-cycle pulse acknowledging an accepted descriptor.
- ov_descriptor  output  40  head-of-FIFO descriptor to the queue manager.
- o_descriptor_valid  output  1  FIFO not empty; ov_descriptor is meaningful.
- i_descriptor_rd  input  1  consumer pops head; honoured only when o_descriptor_valid=1.
- ov_fifo_usedw  output  AW+1  current occupancy, 0..DEPTH.
- o_fifo_full  output  1  occupancy equals DEPTH.
- o_descriptor_drop  output  1  one-cycle pulse: descriptor discarded due to full.
- ov_drop_cnt  output  16  saturating count of dropped descriptors.

Behaviour:
- Reset: one clock, i_rst is synchronous and active-high. While i_rst=1 at a rising edge, all state clears:
  - wr_ptr, rd_ptr, count = 0.
  - o_descriptor_ack = 0, o_descriptor_drop = 0, ov_drop_cnt = 0.
  - Consequently o_descriptor_valid = 0, o_fifo_full = 0, ov_fifo_usedw = 0.
  - Memory contents are not cleared. ov_descriptor reflects mem[rd_ptr] and is don't-care while valid=0.
- Reset mid-operation: contents are lost. In-flight strobes in the reset cycle are ignored and produce no ack or drop.
- Per rising edge, signals are computed from pre-edge state:
  - pop = i_descriptor_rd & (count != 0).
  - push_ok = i_descriptor_wr & ((count < DEPTH) | pop).
  - drop = i_descriptor_wr & ~push_ok.
- push_ok:
  - mem[wr_ptr] <= iv_descriptor.
  - wr_ptr <= wr_ptr+1 mod DEPTH.
  - o_descriptor_ack <= 1 next cycle, otherwise 0. The ack is registered, giving 1-cycle latency.
- pop: rd_ptr <= rd_ptr+1 mod DEPTH.
- count update:
  - push_ok and pop together: count unchanged.
  - push_ok only: count+1.
  - pop only: count-1.
- Simultaneous write while full with a read in the same cycle: the write is accepted and the head is popped. Count stays at DEPTH and there is no drop.
- drop:
  - Descriptor discarded, no ack.
  - o_descriptor_drop <= 1 for one cycle.
  - ov_drop_cnt increments, saturating at 16'hFFFF (no wrap).
- Read while empty: ignored. Pointers and count are unchanged.
- Outputs:
  - o_descriptor_valid = (count != 0).
  - o_fifo_full = (count == DEPTH).
  - ov_fifo_usedw = count.
  - ov_descriptor = mem[rd_ptr], show-ahead.
  - All are derived from registers only, with no combinational path from i_descriptor_wr or i_descriptor_rd.
- Write-to-valid latency: a descriptor written at edge N is visible on ov_descriptor with valid=1 after edge N, so the consumer may pop it in cycle N+1.
- Ordering: strict FIFO. The descriptor is passed through bit-exact; no field decoding.
- Back-to-back writes every cycle are supported; each accepted write yields its own ack pulse, so ack may stay high for consecutive cycles.
- Pointer wrap: both pointers wrap DEPTH-1 -> 0. Full versus empty is distinguished by count, not by pointer equality.

Test Plan:
- Reset/idle: hold i_rst=1 for 2 cycles, then release -> valid=0, full=0, usedw=0, ack=0, drop=0, drop_cnt=0.
- Single descriptor: wr=1 with 40'h12_3456_789A for one cycle -> next cycle ack=1 for exactly one cycle, valid=1, ov_descriptor=40'h12_3456_789A, usedw=1. Then rd=1 -> valid=0, usedw=0.
- Fill and order: 8 consecutive writes of values 1..8 with no reads -> ack high 8 cycles, full=1, usedw=8. Then 8 reads -> outputs 1..8 in order, finishing with valid=0. Repeat twice to exercise pointer wrap.
- Overflow: when full, write 40'hFF -> no ack, drop pulses once, drop_cnt=1, usedw stays 8, head unchanged. Force drop_cnt to 16'hFFFE and drop 3 more -> counter saturates at 16'hFFFF.
- Simultaneous at full: full with head=1, wr=1 (value 9) and rd=1 in the same cycle -> ack=1, drop=0, usedw=8, new head=2. After draining, the last entry out is 9.
- Reset mid-operation: with usedw=5, assert i_rst in the same cycle as wr=1 -> no ack, usedw=0, valid=0. The next write after release is the first descriptor out.
